// File: rtl/fifo_pair_arbiter.sv
// Purpose: arbitrates reads from two upstream FIFOs into one registered output stream.
// Latency: a pop in cycle k delivers valid_out/data_out in cycle k+2 (FIFO read, then output register).
// Backpressure: pops are withheld while down_count >= latched threshold; nothing pops outside ACTIVE.
module fifo_pair_arbiter #(
  parameter int MAIN_SIZE  = 8,
  parameter int CNT_SIZE   = 5,
  parameter int UMBRAL_RST = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 init,
  input  logic [CNT_SIZE-1:0]  umbral_hi,
  input  logic                 fifo0_empty,
  input  logic                 fifo1_empty,
  input  logic                 fifo0_almost_full,
  input  logic                 fifo1_almost_full,
  input  logic                 fifo0_error,
  input  logic                 fifo1_error,
  input  logic [MAIN_SIZE-1:0] fifo0_data,
  input  logic [MAIN_SIZE-1:0] fifo1_data,
  input  logic [CNT_SIZE-1:0]  down_count,
  output logic                 pop0,
  output logic                 pop1,
  output logic [MAIN_SIZE-1:0] data_out,
  output logic                 valid_out,
  output logic [2:0]           state,
  output logic                 idle_out,
  output logic                 error_out,
  output logic [7:0]           sent_count
);

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_ERROR  = 3'd4
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [CNT_SIZE-1:0] umbral_q;
  logic                rr_q;      // favoured FIFO when both are eligible and tied
  logic                rd_vld;    // a pop was issued last cycle; FIFO data is valid now
  logic                rd_src;    // which FIFO that pop went to
  logic                grant0;
  logic                grant1;
  logic                any_error;
  logic                paused;
  logic                can_pop;

  assign any_error = fifo0_error | fifo1_error;
  assign paused    = (down_count >= umbral_q);
  // Error flags gate pops in the same cycle so nothing new is launched once ERROR is due.
  assign can_pop   = (state_q == ST_ACTIVE) && !paused && !any_error;

  assign pop0      = can_pop & grant0;
  assign pop1      = can_pop & grant1;
  assign state     = state_q;
  assign idle_out  = (state_q == ST_IDLE);
  assign error_out = (state_q == ST_ERROR);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_RESET;
    else        state_q <= state_d;
  end

  // Next-state logic; a FIFO error overrides every other transition.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RESET:  state_d = ST_INIT;
      ST_INIT:   if (!init) state_d = ST_IDLE;
      ST_IDLE: begin
        if (init)                              state_d = ST_INIT;
        else if (!fifo0_empty || !fifo1_empty) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: if (fifo0_empty && fifo1_empty && !rd_vld) state_d = ST_IDLE;
      ST_ERROR:  state_d = ST_ERROR;
      default:   state_d = ST_RESET;
    endcase
    if (any_error) state_d = ST_ERROR;
  end

  // Grant selection: single eligible wins; almost-full breaks a tie; otherwise round-robin.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!fifo0_empty && !fifo1_empty) begin
      if (fifo0_almost_full != fifo1_almost_full) grant1 = fifo1_almost_full;
      else                                        grant1 = rr_q;
      grant0 = !grant1;
    end else begin
      grant0 = !fifo0_empty;
      grant1 = !fifo1_empty;
    end
  end

  // Round-robin pointer points away from whichever FIFO was just served.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    rr_q <= 1'b0;
    else if (pop0) rr_q <= 1'b1;
    else if (pop1) rr_q <= 1'b0;
  end

  // Pause threshold is only loaded while in INIT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                   umbral_q <= CNT_SIZE'(UMBRAL_RST);
    else if (state_q == ST_INIT)  umbral_q <= umbral_hi;
  end

  // Read pipeline: remember the pop, then register the FIFO's data one cycle later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_vld     <= 1'b0;
      rd_src     <= 1'b0;
      valid_out  <= 1'b0;
      data_out   <= '0;
      sent_count <= '0;
    end else begin
      rd_vld    <= pop0 | pop1;
      rd_src    <= pop1;
      valid_out <= rd_vld;
      if (rd_vld) begin
        data_out <= rd_src ? fifo1_data : fifo0_data;
        if (sent_count != 8'hFF) sent_count <= sent_count + 8'd1;
      end
    end
  end

endmodule
